fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage with a prefetch queue. Keeps a byte-addressed fetch PC,
//  issues one instruction read at a time over a req/gnt/rvalid memory port, and buffers
//  {pc, instr} pairs in a DEPTH-entry FIFO feeding decode over a valid/ready handshake.
//  Supports branch redirect with flush and discard of in-flight data, and halt.
//  Sits between the instruction memory and the decode stage.
// PARAMETERS
//  ADDR_W    16      fetch address width in bits; PC wraps modulo 2**ADDR_W
//  INSTR_W   16      instruction width in bits (multiple of 8); INSTR_BYTES = INSTR_W/8
//  DEPTH     4       prefetch FIFO entries (power of two, >= 2)
//  RESET_PC  'h0000  fetch PC after reset
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        synchronous, active-high reset
//  halt_program  in   1        level; stop issuing new fetches while high
//  redirect      in   1        pulse; branch/jump taken, flush and refetch
//  redirect_pc   in   ADDR_W   target byte address (used when redirect=1)
//  mem_req       out  1        read request
//  mem_addr      out  ADDR_W   byte address of request
//  mem_gnt       in   1        request accepted this cycle (req&gnt)
//  mem_rvalid    in   1        read data valid for the accepted request
//  mem_rdata     in   INSTR_W  instruction, little-endian (byte at addr in [7:0])
//  if_valid      out  1        head of FIFO valid to decode
//  if_instr      out  INSTR_W  head instruction
//  if_pc         out  ADDR_W   byte address of head instruction
//  if_ready      in   1        decode accepts head (pop when if_valid&if_ready)
//  fifo_count    out  $clog2(DEPTH)+1  entries currently buffered
// BEHAVIOUR
//  - Reset: fetch_pc<=RESET_PC, state IDLE, FIFO empty; mem_req=0, if_valid=0, fifo_count=0.
//  - FSM (fetch_pkg::fetch_state_t): IDLE, REQ, WAIT, DROP.
//    IDLE: if !halt_program && fifo_count<DEPTH -> REQ.
//    REQ : mem_req=1, mem_addr=fetch_pc. On mem_gnt -> WAIT. If halt_program and no gnt -> IDLE
//          (withdrawal legal; a request counts only when req&gnt in the same cycle).
//    WAIT: on mem_rvalid push {fetch_pc, mem_rdata}; fetch_pc += INSTR_BYTES; -> IDLE.
//    DROP: on mem_rvalid discard data, fetch_pc unchanged; -> IDLE.
//  - At most one outstanding request; a request is issued only when fifo_count<DEPTH counting no
//    pops, so a push never finds the FIFO full.
//  - Latency: with gnt in the REQ cycle and rvalid one cycle later, data is visible on if_valid the
//    cycle after rvalid; sustained throughput is one instruction per 3 cycles (IDLE,REQ,WAIT).
//  - redirect (highest priority after rst): FIFO flushed (if_valid=0 next cycle, any same-cycle pop
//    ignored), fetch_pc<=redirect_pc.
//    In IDLE -> IDLE; in REQ without gnt -> IDLE; in REQ with gnt, or WAIT without rvalid -> DROP;
//    WAIT with rvalid in same cycle -> data dropped, -> IDLE; in DROP -> DROP.
//  - halt_program: no new REQ entered; an accepted request still completes and is pushed; FIFO keeps
//    draining to decode. Deassertion resumes from fetch_pc.
//  - PC arithmetic: ADDR_W-bit, wraps (e.g. 0xFFFE + 2 -> 0x0000); redirect_pc used as given.
//  - Simultaneous push and pop: both take effect, count unchanged. Pop on empty is ignored.
//  - mem_addr is don't-care when mem_req=0; outputs driven from registers or FIFO head only.
// STRUCTURE
//  - fetch_pkg: fetch_state_t enum, INSTR_BYTES, the fetch-entry struct {pc, instr} packing.
//  - Sub-module sync_fifo (WIDTH=ADDR_W+INSTR_W, DEPTH) with push/pop/flush/count;
//    top holds FSM, fetch_pc, redirect/discard logic.
// TESTING
//  1 Reset with rst=1 for 2 cycles -> mem_req=0, if_valid=0, fifo_count=0; first req addr 0x0000.
//  2 gnt immediate, rvalid +1 cycle, mem_rdata=0x1234 at 0x0000, if_ready=1
//    -> if_instr=0x1234, if_pc=0x0000; next req addr 0x0002.
//  3 if_ready=0, DEPTH=4 -> exactly 4 pushes (pc 0,2,4,6), fifo_count=4, mem_req stays 0 until
//    one pop, then req addr 0x0008.
//  4 redirect_pc=0x0100 while in WAIT; rvalid 1 cycle later
//    -> data discarded, fifo_count=0, next req addr 0x0100.
//  5 redirect coincident with rvalid and if_valid&if_ready
//    -> no push, pop ignored, FIFO empty, next req 0x0100.
//  6 RESET_PC=0xFFFE, halt after first gnt -> 0xFFFE entry pushed, no further req;
//    release halt -> req addr 0x0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state encoding, default
// widths, and the {pc, instr} prefetch-entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int INSTR_BYTES = DEF_INSTR_W / 8;

  // Entry layout held in the prefetch FIFO: pc in the upper bits, instr below.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int instr_bytes(input int instr_w);
    return instr_w / 8;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is visible on dout while valid.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count = wr_ptr - rd_ptr;
  assign valid = (count != '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Flush beats both push and pop; a pop on empty is simply ignored.
  always_comb begin
    do_push = push && !flush && (count != (AW+1)'(DEPTH));
    do_pop  = pop && !flush && valid;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: one outstanding read over req/gnt/rvalid, results
// buffered in a prefetch FIFO for decode, with redirect flush and halt.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter int               INSTR_W  = 16,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt_program,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [INSTR_W-1:0]         mem_rdata,
  output logic                       if_valid,
  output logic [INSTR_W-1:0]         if_instr,
  output logic [ADDR_W-1:0]          if_pc,
  input  logic                       if_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output fetch_state_t               state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(instr_bytes(INSTR_W));
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]         fetch_pc;
  logic                      push;
  logic [ADDR_W+INSTR_W-1:0] fifo_din;
  logic [ADDR_W+INSTR_W-1:0] fifo_dout;

  always_comb begin
    push     = (state == ST_WAIT) && mem_rvalid && !redirect;
    fifo_din = {fetch_pc, mem_rdata};
  end

  assign mem_addr = fetch_pc;
  assign if_instr = fifo_dout[INSTR_W-1:0];
  assign if_pc    = fifo_dout[ADDR_W+INSTR_W-1:INSTR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      mem_req  <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_REQ:  state <= mem_gnt ? ST_DROP : ST_IDLE;
        ST_WAIT: state <= mem_rvalid ? ST_IDLE : ST_DROP;
        // Stay in DROP until the stale response arrives; if it arrives now we are done.
        ST_DROP: state <= mem_rvalid ? ST_IDLE : ST_DROP;
        default: state <= ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          // Issue only with guaranteed room, so the eventual push never overflows.
          if (!halt_program && (fifo_count < FULL_CNT)) begin
            state   <= ST_REQ;
            mem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state   <= ST_WAIT;
            mem_req <= 1'b0;
          end else if (halt_program) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state    <= ST_IDLE;
            fetch_pc <= fetch_pc + PC_STEP;
          end
        end
        ST_DROP: begin
          if (mem_rvalid) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (if_ready),
    .flush (redirect),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .valid (if_valid),
    .count (fifo_count)
  );

endmodule
